// File: rtl/styler_pixel_serializer.sv
// styler_pixel_serializer: hold + shift double buffer that emits styled glyph rows one pixel per strobe, MSB first.
// Optional STYLER_SER_XSCALE_EN adds i_xscale, which doubles every pixel of the accompanying row horizontally.
module styler_pixel_serializer #(
  parameter int ROW_W  = 16,
  parameter int UCNT_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ROW_W-1:0]  i_row_data,
  input  logic              i_row_valid,
`ifdef STYLER_SER_XSCALE_EN
  input  logic              i_xscale,
`endif
  output logic              o_row_ready,
  input  logic              i_flush,
  input  logic              i_pix_en,
  output logic              o_pix_out,
  output logic              o_pix_valid,
  output logic              o_underrun,
  output logic [UCNT_W-1:0] o_underrun_cnt,
  output logic              o_busy
);

  localparam int CNT_W = $clog2(ROW_W + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(ROW_W);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [UCNT_W-1:0] UCNT_MAX = '1;

  logic [ROW_W-1:0]  r_hold;
  logic              r_hold_full;
  logic              r_hold_xs;
  logic [ROW_W-1:0]  r_shreg;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_sh_xs;
  logic              r_phase;
  logic              r_pix_out;
  logic              r_pix_valid;
  logic              r_underrun;
  logic [UCNT_W-1:0] r_underrun_cnt;

  logic w_in_xs;
  logic w_accept;
  logic w_advance;
  logic w_last_strobe;
  logic w_load;

`ifdef STYLER_SER_XSCALE_EN
  assign w_in_xs = i_xscale;
`else
  assign w_in_xs = 1'b0;
`endif

  // A doubled pixel only advances the shift register on its second strobe.
  assign w_advance     = (r_cnt != '0) && (!r_sh_xs || r_phase);
  assign w_last_strobe = (r_cnt == CNT_ONE) && (!r_sh_xs || r_phase);
  assign w_load        = r_hold_full && ((r_cnt == '0) || (w_last_strobe && i_pix_en));
  assign w_accept      = i_row_valid && !r_hold_full && !i_flush;

  assign o_row_ready    = !r_hold_full && !i_flush;
  assign o_busy         = r_hold_full || (r_cnt != '0);
  assign o_pix_out      = r_pix_out;
  assign o_pix_valid    = r_pix_valid;
  assign o_underrun     = r_underrun;
  assign o_underrun_cnt = r_underrun_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hold         <= '0;
      r_hold_full    <= 1'b0;
      r_hold_xs      <= 1'b0;
      r_shreg        <= '0;
      r_cnt          <= '0;
      r_sh_xs        <= 1'b0;
      r_phase        <= 1'b0;
      r_pix_out      <= 1'b0;
      r_pix_valid    <= 1'b0;
      r_underrun     <= 1'b0;
      r_underrun_cnt <= '0;
    end else if (i_flush) begin
      // Line/frame boundary: drop everything buffered but keep the underrun statistics.
      r_hold_full <= 1'b0;
      r_shreg     <= '0;
      r_cnt       <= '0;
      r_phase     <= 1'b0;
      r_pix_out   <= 1'b0;
      r_pix_valid <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      if (i_pix_en) begin
        if (r_cnt != '0) begin
          r_pix_out   <= r_shreg[ROW_W-1];
          r_pix_valid <= 1'b1;
          if (w_advance) begin
            r_shreg <= r_shreg << 1;
            r_cnt   <= r_cnt - 1'b1;
            r_phase <= 1'b0;
          end else begin
            r_phase <= 1'b1;
          end
        end else begin
          r_pix_out   <= 1'b0;
          r_pix_valid <= 1'b0;
          r_underrun  <= 1'b1;
          if (r_underrun_cnt != UCNT_MAX) begin
            r_underrun_cnt <= r_underrun_cnt + 1'b1;
          end
        end
      end
      // Load overrides the shift above so the next row follows the last pixel seamlessly.
      if (w_load) begin
        r_shreg     <= r_hold;
        r_sh_xs     <= r_hold_xs;
        r_cnt       <= CNT_FULL;
        r_phase     <= 1'b0;
        r_hold_full <= 1'b0;
      end
      if (w_accept) begin
        r_hold      <= i_row_data;
        r_hold_xs   <= w_in_xs;
        r_hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_styler_pixel_serializer.sv
// Bench for styler_pixel_serializer: pixel-queue reference model checked every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_styler_pixel_serializer;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic [15:0] row_data  = '0;
  logic        row_valid = 1'b0;
  logic        flush     = 1'b0;
  logic        pix_en    = 1'b0;
  logic        xscale    = 1'b0;
  logic        row_ready, pix_out, pix_valid, underrun, busy;
  logic [7:0]  underrun_cnt;

  always #5 clk = ~clk;

  styler_pixel_serializer #(.ROW_W(16), .UCNT_W(8)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_row_data     (row_data),
    .i_row_valid    (row_valid),
`ifdef STYLER_SER_XSCALE_EN
    .i_xscale       (xscale),
`endif
    .o_row_ready    (row_ready),
    .i_flush        (flush),
    .i_pix_en       (pix_en),
    .o_pix_out      (pix_out),
    .o_pix_valid    (pix_valid),
    .o_underrun     (underrun),
    .o_underrun_cnt (underrun_cnt),
    .o_busy         (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the buffered pixels are simply a queue of bits waiting to be shown.
  bit        pq[$];
  logic [15:0] m_hold = '0;
  bit        m_hold_xs = 0, m_hold_full = 0;
  bit        m_out = 0, m_valid = 0, m_und = 0;
  int        m_ucnt = 0;
  bit        m_load, m_acc;

  always @(posedge clk) begin
    if (rst) begin
      pq.delete();
      m_hold_full = 0; m_out = 0; m_valid = 0; m_und = 0; m_ucnt = 0;
    end else if (flush) begin
      pq.delete();
      m_hold_full = 0; m_out = 0; m_valid = 0; m_und = 0;
    end else begin
      m_load = m_hold_full && (pq.size() == 0 || (pq.size() == 1 && pix_en));
      m_acc  = row_valid && !m_hold_full;
      m_und  = 0;
      if (pix_en) begin
        if (pq.size() > 0) begin
          m_out = pq.pop_front(); m_valid = 1;
        end else begin
          m_out = 0; m_valid = 0; m_und = 1;
          if (m_ucnt < 255) m_ucnt++;
        end
      end
      if (m_load) begin
        for (int i = 15; i >= 0; i--) begin
          pq.push_back(m_hold[i]);
          if (m_hold_xs) pq.push_back(m_hold[i]);
        end
        m_hold_full = 0;
      end
      if (m_acc) begin
        m_hold = row_data; m_hold_xs = xscale; m_hold_full = 1;
      end
    end
  end

  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pix_out",      {31'd0, pix_out},      {31'd0, m_out});
      chk("pix_valid",    {31'd0, pix_valid},    {31'd0, m_valid});
      chk("underrun",     {31'd0, underrun},     {31'd0, m_und});
      chk("underrun_cnt", {24'd0, underrun_cnt}, m_ucnt);
      chk("busy",         {31'd0, busy},         {31'd0, (m_hold_full || pq.size() != 0)});
      chk("row_ready",    {31'd0, row_ready},    {31'd0, (!m_hold_full && !flush)});
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic send_row(input logic [15:0] d, input bit xs);
    bit r;
    r = 0;
    row_data = d; row_valid = 1'b1; xscale = xs;
    for (int k = 0; k < 64; k++) begin
      r = row_ready;
      step();
      if (r) break;
    end
    row_valid = 1'b0; xscale = 1'b0;
    chk("send_row_handshake", {31'd0, r}, 32'd1);
  endtask

  logic [15:0] cap16;
  logic [31:0] cap32;
  bit          allv, anyv, anyu;
  int          ucount;

  initial begin
    rst = 1'b1;
    step();
    chk_en = 1;
    step();
    rst = 1'b0;
    step();
    chk("reset_row_ready",    {31'd0, row_ready},    32'd1);
    chk("reset_busy",         {31'd0, busy},         32'd0);
    chk("reset_underrun_cnt", {24'd0, underrun_cnt}, 32'd0);
    chk("reset_pix_valid",    {31'd0, pix_valid},    32'd0);

    // Single row A5C3
    send_row(16'hA5C3, 0);
    step();
    pix_en = 1'b1; allv = 1; anyu = 0; cap16 = '0;
    for (int i = 0; i < 16; i++) begin
      step();
      cap16 = {cap16[14:0], pix_out};
      allv &= pix_valid; anyu |= underrun;
    end
    pix_en = 1'b0;
    chk("a5c3_sequence", {16'd0, cap16}, 32'h0000A5C3);
    chk("a5c3_all_valid", {31'd0, allv}, 32'd1);
    chk("a5c3_no_underrun", {31'd0, anyu}, 32'd0);
    chk("a5c3_idle_after", {31'd0, busy}, 32'd0);
    step();

    // Back-to-back FFFF then 0000, no gap strobe
    send_row(16'hFFFF, 0);
    row_data = 16'h0000; row_valid = 1'b1;
    step();
    pix_en = 1'b1;
    chk("b2b_ready_after_load", {31'd0, row_ready}, 32'd1);
    allv = 1; cap32 = '0;
    for (int i = 0; i < 32; i++) begin
      step();
      row_valid = 1'b0;
      cap32 = {cap32[30:0], pix_out};
      allv &= pix_valid;
    end
    pix_en = 1'b0;
    chk("b2b_sequence", cap32, 32'hFFFF0000);
    chk("b2b_no_gap", {31'd0, allv}, 32'd1);
    step();

    // Underrun saturation
    pix_en = 1'b1; ucount = 0; anyv = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (underrun) ucount++;
      anyv |= pix_valid;
    end
    pix_en = 1'b0;
    chk("underrun_pulses", ucount, 32'd300);
    chk("underrun_sat", {24'd0, underrun_cnt}, 32'd255);
    chk("underrun_no_valid", {31'd0, anyv}, 32'd0);
    step();

    // Flush mid-row with a competing row_valid and pix_en
    send_row(16'h8001, 0);
    step();
    pix_en = 1'b1;
    for (int i = 0; i < 5; i++) step();
    flush = 1'b1; row_valid = 1'b1; row_data = 16'h1234;
    step();
    flush = 1'b0; row_valid = 1'b0; pix_en = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_pix_valid", {31'd0, pix_valid}, 32'd0);
    chk("flush_no_underrun", {31'd0, underrun}, 32'd0);
    pix_en = 1'b1;
    step();
    pix_en = 1'b0;
    chk("flush_then_underrun", {31'd0, underrun}, 32'd1);
    step();

    // Reset mid-row
    send_row(16'hF0F0, 0);
    step();
    pix_en = 1'b1;
    for (int i = 0; i < 7; i++) step();
    pix_en = 1'b0; rst = 1'b1;
    step();
    chk("rst_pix_out", {31'd0, pix_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_row_ready", {31'd0, row_ready}, 32'd1);
    chk("rst_underrun_cnt", {24'd0, underrun_cnt}, 32'd0);
    rst = 1'b0;
    step();

`ifdef STYLER_SER_XSCALE_EN
    // Horizontally doubled row
    send_row(16'hC000, 1);
    step();
    pix_en = 1'b1; cap32 = '0; allv = 1;
    for (int i = 0; i < 32; i++) begin
      step();
      cap32 = {cap32[30:0], pix_out};
      allv &= pix_valid;
    end
    chk("xscale_sequence", cap32, 32'hF0000000);
    chk("xscale_all_valid", {31'd0, allv}, 32'd1);
    step();
    chk("xscale_33rd_underrun", {31'd0, underrun}, 32'd1);
    pix_en = 1'b0;
    step();
`endif

    // Randomized traffic with varying strobe density
    for (int c = 0; c < 4000; c++) begin
      int dens;
      dens = (c / 500) % 4;
      row_valid = 1'($urandom_range(0, 1));
      row_data  = 16'($urandom);
      pix_en    = ($urandom_range(0, 9) < 3 + 2 * dens);
      flush     = ($urandom_range(0, 59) == 0);
      rst       = ($urandom_range(0, 299) == 0);
`ifdef STYLER_SER_XSCALE_EN
      xscale    = 1'($urandom_range(0, 1));
`endif
      step();
    end
    row_valid = 1'b0; pix_en = 1'b0; flush = 1'b0; rst = 1'b0; xscale = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
